// File: rtl/cpu_pkg.sv
// Shared CPU/bus definitions: AHB transfer encodings, size codes, lane decode
package cpu_pkg;

    typedef enum logic [1:0] {
        AHB_IDLE   = 2'b00,
        AHB_BUSY   = 2'b01,
        AHB_NONSEQ = 2'b10,
        AHB_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        RDATA,
        RWAIT,
        WDATA,
        ERR1,
        ERR2
    } slv_state_e;

    // Size/alignment legality of a transfer
    function automatic logic size_legal(input logic [2:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~off[0];
            HSIZE_WORD: ok = (off == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Big-endian byte enables: be[3] is bits 31:24 (byte offset 0)
    function automatic logic [3:0] be_from_size(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b1000 >> off;
            HSIZE_HALF: be = off[1] ? 4'b0011 : 4'b1100;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_slv_if.sv
// AHB-Lite bus bundle between the CPU memory stage and the SRAM responder
interface ahb_sram_slv_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HREADY, HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_sram_wbuf.sv
// One-entry posted write buffer with address compare and byte-merge forwarding
module ahb_sram_wbuf #(
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          drain,
    input  logic [AW-3:0] load_addr,
    input  logic [3:0]    load_be,
    input  logic [31:0]   load_data,
    input  logic [AW-3:0] cmp_addr,
    input  logic [31:0]   ram_q,
    output logic          valid,
    output logic [AW-3:0] addr,
    output logic [3:0]    be,
    output logic [31:0]   data,
    output logic [31:0]   fwd_data
);

    logic hit;

    // Valid flag: a load wins over a same-cycle drain of the previous entry
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    // Entry payload; only meaningful while valid is set
    always_ff @(posedge clk) begin
        if (load) begin
            addr <= load_addr;
            be   <= load_be;
            data <= load_data;
        end
    end

    assign hit = valid && (addr == cmp_addr);

    // Bytes held in the buffer override the stale RAM bytes
    always_comb begin
        fwd_data = ram_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (hit && be[i]) begin
                fwd_data[8*i +: 8] = data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ahb_sram_slv.sv
// AHB-Lite responder for a single-port synchronous SRAM with posted writes
module ahb_sram_slv
    import cpu_pkg::*;
#(
    parameter int AW      = 18,
    parameter int RD_WAIT = 0
) (
    input  logic           clk,
    input  logic           rst,
    ahb_sram_slv_if.slave  ahb,
    output logic           ram_en,
    output logic           ram_we,
    output logic [AW-3:0]  ram_a,
    output logic [3:0]     ram_be,
    output logic [31:0]    ram_d,
    input  logic [31:0]    ram_q
);

    localparam int         WA        = AW - 2;
    localparam logic [2:0] WAIT_LOAD = (RD_WAIT > 0) ? 3'(RD_WAIT - 1) : 3'd0;

    slv_state_e state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [WA-1:0] waddr_q, raddr_q;
    logic [3:0]    wbe_q;
    logic [31:0]   hrdata_q;

    logic [WA-1:0] word_addr;
    logic [1:0]    byte_off;
    logic          req, accept, legal;
    logic          collision, rd_issue, wr_accept, err_accept;
    logic          ready, resp, hrdata_cap;

    logic          buf_valid, buf_load, buf_drain;
    logic [WA-1:0] buf_addr;
    logic [3:0]    buf_be;
    logic [31:0]   buf_data, fwd_data;

    logic          unused_bits;

    assign unused_bits = ^{ahb.HADDR, ahb.HTRANS[0]};

    assign word_addr  = ahb.HADDR[AW-1:2];
    assign byte_off   = ahb.HADDR[1:0];
    assign req        = ahb.HSEL & ahb.HTRANS[1];
    assign accept     = req & ahb.HREADY;
    assign legal      = size_legal(ahb.HSIZE, byte_off);

    // Read arriving while the old entry still occupies the buffer: the drain
    // takes the RAM port, so the write data phase is stretched by one cycle
    // and the read is re-presented once the buffer is free.
    assign collision  = (state_q == WDATA) & buf_valid & req & ~ahb.HWRITE & legal;
    assign rd_issue   = accept & ~ahb.HWRITE & legal & ~collision;
    assign wr_accept  = accept & ahb.HWRITE & legal;
    assign err_accept = accept & ~legal;

    assign buf_load   = (state_q == WDATA) & ~collision;
    assign buf_drain  = buf_valid & ~rd_issue;

    ahb_sram_wbuf #(.AW(AW)) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .drain     (buf_drain),
        .load_addr (waddr_q),
        .load_be   (wbe_q),
        .load_data (ahb.HWDATA),
        .cmp_addr  (raddr_q),
        .ram_q     (ram_q),
        .valid     (buf_valid),
        .addr      (buf_addr),
        .be        (buf_be),
        .data      (buf_data),
        .fwd_data  (fwd_data)
    );

    // State, wait counter and read-data holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hrdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (hrdata_cap) begin
                hrdata_q <= fwd_data;
            end
        end
    end

    // Address-phase attributes carried into the data phase
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            waddr_q <= word_addr;
            wbe_q   <= be_from_size(ahb.HSIZE, byte_off);
        end
        if (rd_issue) begin
            raddr_q <= word_addr;
        end
    end

    // Response per state and next-state selection
    always_comb begin
        ready      = 1'b1;
        resp       = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        hrdata_cap = 1'b0;

        case (state_q)
            IDLE:  ;
            RDATA: hrdata_cap = (RD_WAIT == 0);
            RWAIT: begin
                ready      = 1'b0;
                hrdata_cap = (cnt_q == WAIT_LOAD);
                if (cnt_q == 3'd0) begin
                    state_d = RDATA;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WDATA: ready = ~collision;
            ERR1: begin
                ready   = 1'b0;
                resp    = 1'b1;
                state_d = ERR2;
            end
            ERR2:  resp = 1'b1;
            default: state_d = IDLE;
        endcase

        if (ready) begin
            if (err_accept) begin
                state_d = ERR1;
            end else if (rd_issue) begin
                state_d = (RD_WAIT == 0) ? RDATA : RWAIT;
                cnt_d   = WAIT_LOAD;
            end else if (wr_accept) begin
                state_d = WDATA;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Bus outputs; in a reset cycle everything is forced to its reset value
    always_comb begin
        ahb.HREADYOUT = ready;
        ahb.HRESP     = resp;
        ahb.HRDATA    = (state_q == RDATA && RD_WAIT == 0) ? fwd_data : hrdata_q;
        if (rst) begin
            ahb.HREADYOUT = 1'b1;
            ahb.HRESP     = 1'b0;
            ahb.HRDATA    = '0;
        end
    end

    // RAM port: reads have priority, the buffer drains whenever the port is free
    always_comb begin
        ram_en = 1'b0;
        ram_we = 1'b0;
        ram_a  = buf_addr;
        ram_be = buf_be;
        ram_d  = buf_data;
        if (!rst) begin
            if (rd_issue) begin
                ram_en = 1'b1;
                ram_a  = word_addr;
                ram_be = '1;
            end else if (buf_valid) begin
                ram_en = 1'b1;
                ram_we = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_slv.sv
// Directed bench for ahb_sram_slv: forwarding, byte lanes, collision, waits, errors, reset
module tb_ahb_sram_slv;
    import cpu_pkg::*;

    localparam int AW = 10;

    logic clk;
    logic rst;

    ahb_sram_slv_if bus();
    ahb_sram_slv_if bus2();

    assign bus.HREADY  = bus.HREADYOUT;
    assign bus2.HREADY = bus2.HREADYOUT;

    logic          ram_en, ram_we, ram2_en, ram2_we;
    logic [AW-3:0] ram_a, ram2_a;
    logic [3:0]    ram_be, ram2_be;
    logic [31:0]   ram_d, ram_q, ram2_d, ram2_q;

    logic [31:0] mem  [256];
    logic [31:0] mem2 [256];

    int unsigned en_cnt = 0;
    int unsigned n_assert = 0;
    int unsigned n_fail = 0;
    int unsigned waits = 0;
    int unsigned en_base = 0;

    ahb_sram_slv #(.AW(AW), .RD_WAIT(0)) dut (
        .clk    (clk),
        .rst    (rst),
        .ahb    (bus),
        .ram_en (ram_en),
        .ram_we (ram_we),
        .ram_a  (ram_a),
        .ram_be (ram_be),
        .ram_d  (ram_d),
        .ram_q  (ram_q)
    );

    ahb_sram_slv #(.AW(AW), .RD_WAIT(2)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .ahb    (bus2),
        .ram_en (ram2_en),
        .ram_we (ram2_we),
        .ram_a  (ram2_a),
        .ram_be (ram2_be),
        .ram_d  (ram2_d),
        .ram_q  (ram2_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM models: registered read data, held when not enabled
    always @(posedge clk) begin
        if (ram_en) begin
            en_cnt <= en_cnt + 1;
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_a][8*b +: 8] <= ram_d[8*b +: 8];
            end else begin
                ram_q <= mem[ram_a];
            end
        end
    end

    always @(posedge clk) begin
        if (ram2_en) begin
            if (ram2_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram2_be[b]) mem2[ram2_a][8*b +: 8] <= ram2_d[8*b +: 8];
            end else begin
                ram2_q <= mem2[ram2_a];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr);
        bus.HSEL   = sel;
        bus.HTRANS = trans;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        bus.HADDR  = addr;
    endtask

    task automatic drv2(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [2:0] size, input logic [31:0] addr);
        bus2.HSEL   = sel;
        bus2.HTRANS = trans;
        bus2.HWRITE = wr;
        bus2.HSIZE  = size;
        bus2.HADDR  = addr;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]  = '0;
            mem2[i] = '0;
        end
        mem[10]  = 32'hCAFE_F00D;
        mem[20]  = 32'h5A5A_5A5A;
        mem2[12] = 32'h1234_5678;
        ram_q  = '0;
        ram2_q = '0;

        rst = 1'b1;
        drv(1'b0, AHB_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        drv2(1'b0, AHB_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        bus.HWDATA  = '0;
        bus2.HWDATA = '0;
        tick;
        tick;
        rst = 1'b0;
        #3;
        chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        chk("rst_hresp",     32'(bus.HRESP),     32'd0);
        chk("rst_hrdata",    bus.HRDATA,         32'h0);
        chk("rst_ram_en",    32'(ram_en),        32'd0);
        chk("rst_ram_we",    32'(ram_we),        32'd0);

        // Word write then back-to-back read of the same word: forwarded
        tick; drv(1'b1, AHB_NONSEQ, 1'b1, HSIZE_WORD, 32'h0000_0010); #3;
        chk("t1_wa_ready", 32'(bus.HREADYOUT), 32'd1);
        chk("t1_wa_ram_en", 32'(ram_en), 32'd0);
        tick; bus.HWDATA = 32'h1122_3344; drv(1'b1, AHB_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0010); #3;
        chk("t1_rd_en", 32'({ram_en, ram_we}), 32'h2);
        chk("t1_rd_a", 32'(ram_a), 32'd4);
        chk("t1_rd_ready", 32'(bus.HREADYOUT), 32'd1);
        tick; drv(1'b0, AHB_IDLE, 1'b0, HSIZE_WORD, 32'h0); #3;
        chk("t1_hrdata", bus.HRDATA, 32'h1122_3344);
        chk("t1_ready", 32'(bus.HREADYOUT), 32'd1);
        chk("t1_drain_we", 32'({ram_en, ram_we}), 32'h3);
        chk("t1_drain_a", 32'(ram_a), 32'd4);
        chk("t1_drain_be", 32'(ram_be), 32'hF);
        chk("t1_drain_d", ram_d, 32'h1122_3344);
        tick; #3;
        chk("t1_idle_en", 32'(ram_en), 32'd0);
        chk("t1_mem", mem[4], 32'h1122_3344);

        // Byte write at offset 01, then word read merges lane 23:16
        tick; drv(1'b1, AHB_NONSEQ, 1'b1, HSIZE_BYTE, 32'h0000_0011); #3;
        chk("t2_wa_ready", 32'(bus.HREADYOUT), 32'd1);
        tick; bus.HWDATA = 32'hEEAB_EEEE; drv(1'b1, AHB_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0010); #3;
        chk("t2_rd_en", 32'({ram_en, ram_we}), 32'h2);
        tick; drv(1'b0, AHB_IDLE, 1'b0, HSIZE_WORD, 32'h0); #3;
        chk("t2_hrdata", bus.HRDATA, 32'h11AB_3344);
        chk("t2_drain_be", 32'(ram_be), 32'h4);
        chk("t2_drain_we", 32'({ram_en, ram_we}), 32'h3);
        tick; #3;
        chk("t2_mem", mem[4], 32'h11AB_3344);

        // W(0x20), W(0x24), read 0x28 in W(0x24) data phase: one wait state
        tick; drv(1'b1, AHB_NONSEQ, 1'b1, HSIZE_WORD, 32'h0000_0020); #3;
        tick; bus.HWDATA = 32'hA0A0_A0A1; drv(1'b1, AHB_NONSEQ, 1'b1, HSIZE_WORD, 32'h0000_0024); #3;
        chk("t3_w2_ready", 32'(bus.HREADYOUT), 32'd1);
        chk("t3_w2_en", 32'(ram_en), 32'd0);
        waits = 0;
        tick; bus.HWDATA = 32'hB1B2_B3B4; drv(1'b1, AHB_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0028); #3;
        if (!bus.HREADYOUT) waits++;
        chk("t3_col_ready", 32'(bus.HREADYOUT), 32'd0);
        chk("t3_col_we", 32'({ram_en, ram_we}), 32'h3);
        chk("t3_col_a", 32'(ram_a), 32'd8);
        chk("t3_col_d", ram_d, 32'hA0A0_A0A1);
        tick; #3;
        if (!bus.HREADYOUT) waits++;
        chk("t3_re_ready", 32'(bus.HREADYOUT), 32'd1);
        chk("t3_re_en", 32'({ram_en, ram_we}), 32'h2);
        chk("t3_re_a", 32'(ram_a), 32'd10);
        tick; drv(1'b0, AHB_IDLE, 1'b0, HSIZE_WORD, 32'h0); #3;
        if (!bus.HREADYOUT) waits++;
        chk("t3_hrdata", bus.HRDATA, 32'hCAFE_F00D);
        chk("t3_drain_a", 32'(ram_a), 32'd9);
        chk("t3_drain_d", ram_d, 32'hB1B2_B3B4);
        chk("t3_waits", waits, 32'd1);
        tick; #3;
        chk("t3_mem8", mem[8], 32'hA0A0_A0A1);
        chk("t3_mem9", mem[9], 32'hB1B2_B3B4);

        // RD_WAIT=2 instance: two low cycles then data
        tick; drv2(1'b1, AHB_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0030); #3;
        chk("t4_rd_en", 32'({ram2_en, ram2_we}), 32'h2);
        chk("t4_a_ready", 32'(bus2.HREADYOUT), 32'd1);
        tick; drv2(1'b0, AHB_IDLE, 1'b0, HSIZE_WORD, 32'h0); #3;
        chk("t4_wait1", 32'(bus2.HREADYOUT), 32'd0);
        tick; #3;
        chk("t4_wait2", 32'(bus2.HREADYOUT), 32'd0);
        tick; #3;
        chk("t4_ready", 32'(bus2.HREADYOUT), 32'd1);
        chk("t4_hresp", 32'(bus2.HRESP), 32'd0);
        chk("t4_hrdata", bus2.HRDATA, 32'h1234_5678);

        // Illegal size, then misaligned half chained from ERR2, then legal read
        tick; en_base = en_cnt; drv(1'b1, AHB_NONSEQ, 1'b0, 3'b011, 32'h0000_0040); #3;
        chk("t5_a_ready", 32'(bus.HREADYOUT), 32'd1);
        chk("t5_a_en", 32'(ram_en), 32'd0);
        tick; drv(1'b0, AHB_IDLE, 1'b0, HSIZE_WORD, 32'h0); #3;
        chk("t5_err1", 32'({bus.HREADYOUT, bus.HRESP}), 32'h1);
        tick; drv(1'b1, AHB_NONSEQ, 1'b1, HSIZE_HALF, 32'h0000_0041); #3;
        chk("t5_err2", 32'({bus.HREADYOUT, bus.HRESP}), 32'h3);
        tick; bus.HWDATA = 32'hFFFF_FFFF; drv(1'b0, AHB_IDLE, 1'b0, HSIZE_WORD, 32'h0); #3;
        chk("t5_h_err1", 32'({bus.HREADYOUT, bus.HRESP}), 32'h1);
        tick; drv(1'b1, AHB_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0010); #3;
        chk("t5_h_err2", 32'({bus.HREADYOUT, bus.HRESP}), 32'h3);
        chk("t5_no_ram", en_cnt - en_base, 32'd0);
        tick; drv(1'b0, AHB_IDLE, 1'b0, HSIZE_WORD, 32'h0); #3;
        chk("t5_ok", 32'({bus.HREADYOUT, bus.HRESP}), 32'h2);
        chk("t5_hrdata", bus.HRDATA, 32'h11AB_3344);

        // Reset while the buffer holds a write: the write is discarded
        tick; drv(1'b1, AHB_NONSEQ, 1'b1, HSIZE_WORD, 32'h0000_0050); #3;
        tick; bus.HWDATA = 32'hDEAD_BEEF; drv(1'b0, AHB_IDLE, 1'b0, HSIZE_WORD, 32'h0); #3;
        tick; rst = 1'b1; #3;
        chk("t6_rst_en", 32'({ram_en, ram_we}), 32'h0);
        chk("t6_rst_out", 32'({bus.HREADYOUT, bus.HRESP}), 32'h2);
        tick; rst = 1'b0; drv(1'b1, AHB_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0050); #3;
        chk("t6_hrdata0", bus.HRDATA, 32'h0);
        chk("t6_rd_en", 32'({ram_en, ram_we}), 32'h2);
        tick; drv(1'b0, AHB_IDLE, 1'b0, HSIZE_WORD, 32'h0); #3;
        chk("t6_hrdata", bus.HRDATA, 32'h5A5A_5A5A);
        chk("t6_no_drain", 32'(ram_en), 32'd0);
        chk("t6_mem", mem[20], 32'h5A5A_5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slv.md
Name: ahb_sram_slv

Overview:
AHB-Lite responder fronting a single-port synchronous SRAM. It is the target side of the bus the CPU memory-access stage drives: it decodes HTRANS/HSIZE/HADDR/HWRITE into big-endian byte-lane SRAM accesses. A one-entry posted write buffer with read forwarding lets back-to-back write/read run without structural stalls. Illegal transfers receive a two-cycle ERROR response.

Parameters:
AW, 18, byte-address bits decoded inside the region (RAM depth = 2^(AW-2) words)
RD_WAIT, 0, extra wait states inserted in every read data phase (0..7)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
HSEL  in  1  slave select
HADDR  in  32  address; only [AW-1:0] used
HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HWRITE  in  1  1=write
HSIZE  in  3  000 byte, 001 half, 010 word; others illegal
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus-wide ready (previous transfer complete)
HREADYOUT  out  1  this slave's ready
HRESP  out  1  0 OKAY, 1 ERROR
HRDATA  out  32  read data
ram_en  out  1  SRAM access strobe
ram_we  out  1  SRAM write
ram_a  out  AW-2  SRAM word address
ram_be  out  4  byte enables, be[3] = bits 31:24
ram_d  out  32  SRAM write data
ram_q  in  32  SRAM read data, valid the cycle after ram_en & ~ram_we, held while ram_en low

Behaviour:
- Transfer accepted when HSEL & HREADY & HTRANS[1]. BUSY/IDLE produce an OKAY zero-wait response and no RAM access.
- Lanes are big-endian: byte offset 00 -> be 1000, 01 -> 0100, 10 -> 0010, 11 -> 0001; half at offset 0 -> 1100, offset 2 -> 0011; word -> 1111.
- Illegal: HSIZE > 010, half with HADDR[0]=1, word with HADDR[1:0]!=00. Response: cycle 1 HREADYOUT=0 HRESP=1; cycle 2 HREADYOUT=1 HRESP=1. No RAM access and no buffer update.
- FSM states: IDLE, RDATA (read data phase), RWAIT (counts RD_WAIT), WDATA, ERR1, ERR2. Any accepted transfer in a completing data phase chains directly to the next state.
- Read: ram_en=1, ram_we=0 in the address-phase cycle. HRDATA = ram_q merged with the buffer when the word address equals the buffer address and the buffer is valid: bytes whose buffer be bit is set come from the buffer. RD_WAIT=0 gives a zero-wait read; otherwise HREADYOUT is low for RD_WAIT cycles. HRDATA carries the full 32-bit word; the master extracts the lane.
- Write: address, be and size are latched in the address phase. In the data phase, HWDATA is captured into the buffer (valid, word address, be, data). Non-enabled byte data is don't-care.
- Drain: the buffer commits to RAM (ram_en=ram_we=1, ram_a/ram_be/ram_d from the buffer) in any cycle where no read is issued to RAM. It is cleared the same cycle unless it is refilled in that cycle.
- Collision: write data phase with the buffer still valid and a read accepted in the same cycle. Insert one wait state (HREADYOUT=0). The drain takes the RAM port, the read address phase is re-presented next cycle, and the new write is captured next cycle.
- Write data phase with the buffer valid and no read issued: drain the old entry and load the new one in the same cycle.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, ram_en=0, ram_we=0, buffer valid=0, state IDLE.
- Reset mid-operation: a pending buffered write is discarded and the in-flight response is abandoned.
- HRDATA holds its last value outside read data phases.

Decomposition:
- Shared package (cpu_pkg): HTRANS encodings (AHB_IDLE/BUSY/NONSEQ/SEQ), HSIZE codes, and a byte-enable-from-size/offset function also used by the master side.
- One sub-module, ahb_sram_wbuf: buffer storage, address compare and byte-merge forwarding.

Test Plan:
- Word write 0x0000_0010 <- 0x1122_3344, then a read of the same address back-to-back -> HRDATA=0x1122_3344 forwarded from the buffer, zero wait; RAM write occurs when the port is free.
- Byte write 0xAB at offset 01 over a word 0x1122_3344, then a word read -> be=0100, HRDATA=0x11AB_3344.
- Sequence W(0x20), W(0x24) address phase, with a read at 0x28 during the W(0x24) data phase -> exactly one wait state, both writes land in RAM, read data correct.
- RD_WAIT=2, word read -> HREADYOUT low for 2 cycles, then data with HRESP=0.
- HSIZE=011 or half access at 0x...1 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (1,1); ram_en never asserted; next legal transfer completes OKAY.
- Reset asserted while the buffer is valid -> ram_we stays 0, a subsequent read returns the old RAM contents, and all outputs are at reset values.
